sha256_padder: RTL and testbench
================================

# sha256_padder

Front-end message preprocessor for the SHA-256 datapath. It accepts a byte stream with a valid/ready handshake and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. It then emits 512-bit blocks over a second valid/ready handshake. Its output is the block producer that feeds the message-schedule load port (`M`, first word in `[511:480]`). `blk_first` and `blk_last` tell the downstream controller when to load the initial hash value and when to publish the digest.

## Interface
- `LEN_W`, 64: width of the internal bit-length counter (1..64). It is zero-extended into the 64-bit length field.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_data`  in  8  message byte.
- `in_valid`  in  1  `in_data`/`in_last`/`in_empty` are valid.
- `in_last`  in  1  this transfer ends the message.
- `in_empty`  in  1  only honoured with `in_last`: the transfer carries no byte (`in_data` is ignored). Ignored when `in_last`=0.
- `in_ready`  out  1  byte accepted on `in_valid & in_ready`.
- `blk_data`  out  512  padded block; byte 0 in `[511:504]`, word 0 in `[511:480]`.
- `blk_valid`  out  1  block available.
- `blk_first`  out  1  block is the first of its message; qualified by `blk_valid`.
- `blk_last`  out  1  block is the final block of its message; qualified by `blk_valid`.
- `blk_ready`  in  1  block consumed on `blk_valid & blk_ready`.

## Operation
- **States**
  - `FILL`: `in_ready`=1.
  - `SEND_MID`: full data block, not last; returns to `FILL`.
  - `SEND_X`: non-final block followed by a generated tail block.
  - `SEND_FINAL`: `blk_last`=1.
  - `in_ready`=0 in every `SEND_*` state.
- **Registers**
  - `bcnt` (0..63): byte index in the current block.
  - `bitlen` (`LEN_W`): message bit count, +8 per accepted byte, wraps modulo 2^`LEN_W`.
  - `first_pend`.
- **`FILL`, accepted non-last byte**
  - Write `buf[bcnt]`, `bcnt`++.
  - If `bcnt` was 63: go to `SEND_MID` and set `bcnt`=0.
- **`FILL`, accepted last transfer**
  - If not `in_empty`, write the byte and add 8 to `bitlen`.
  - n = bytes now in the block (0..64).
  - n ≤ 55: `buf[n]`=0x80, bytes n+1..55 = 0, bytes 56..63 = length → `SEND_FINAL`.
  - 56 ≤ n ≤ 63: `buf[n]`=0x80, remainder 0 → `SEND_X`.
  - n = 64: block emitted unchanged → `SEND_X`.
- **`SEND_X` handshake**
  - Buffer is rebuilt as the tail block → `SEND_FINAL`.
  - Tail block: all zero, with byte 0 = 0x80 only if the 0x80 byte was not already placed, and the length in bytes 56..63.
- **`SEND_FINAL` handshake**
  - Clear `bitlen`, `bcnt`, `buf`; set `first_pend`; go to `FILL`.
- **`blk_first`**
  - Equals `first_pend` while `blk_valid`.
  - `first_pend` clears on the handshake of the message's first block.
- **Reset (`rst`=0)**, values in the cycle after the reset edge:
  - State = `FILL`; `in_ready`=1 (it is 0 while `rst` is low).
  - `blk_valid`=0, `blk_first`=0, `blk_last`=0, `blk_data`=0.
  - `bitlen`=0, `bcnt`=0, `first_pend`=1.
  - Any partial message or pending block is discarded; reset overrides a simultaneous handshake.

## Timing
- A byte that completes a block, or a last transfer accepted at edge t, gives `blk_valid`=1 from cycle t+1.
- Output stability: `blk_data`, `blk_first` and `blk_last` are registered and held constant while `blk_valid & ~blk_ready`. `blk_valid` never drops without a handshake.
- `SEND_MID`/`SEND_FINAL` handshake at edge t: `in_ready`=1 from t+1. There is no combinational path from `blk_ready` to `in_ready`.
- `SEND_X` handshake at edge t: tail block valid from t+1.
- Sustained rate: 64 accept cycles plus at least 1 output cycle per block.

## Structure
- Shared package `sha256_pkg`:
  - `BLK_W`=512, `PAD_BYTE`=8'h80, `LEN_FIELD_W`=64.
  - `pad_state_t` enum (`FILL`, `SEND_MID`, `SEND_X`, `SEND_FINAL`).
- One sub-module, `sha256_blk_buf`: 64×8 register file with
  - byte write at index,
  - 0x80 insert plus clear-from-index,
  - length-field insert,
  - full clear,
  - flat 512-bit output.
- FSM and counters stay in `sha256_padder`.

## Test plan
- **"abc"** (0x61,0x62,0x63, `in_last` on 0x63), `blk_ready`=1 → one block: word0=0x61626380, words 1–14=0, word15=0x00000018; `blk_first`=`blk_last`=1; `blk_valid` one cycle after the last byte.
- **Empty message** (single transfer, `in_last`=`in_empty`=1) → one block: word0=0x80000000, all others 0; `first`=`last`=1.
- **Pad-byte boundary**
  - 55×0x61 → single block: byte 55=0x80, word15=0x000001B8.
  - 56×0x61 → block 1: byte 56=0x80, `last`=0. Block 2: all zero except word15=0x000001C0, `first`=0, `last`=1.
- **Full last block**: 64×0x61 with `in_last` on byte 64 → block 1 = all 0x61, `first`=1, `last`=0. Block 2: word0=0x80000000, word15=0x00000200, `last`=1.
- **Backpressure**: "abc" with `blk_ready`=0 for 10 cycles → `blk_data`/`blk_valid` stable, `in_ready`=0, no byte accepted. Then a second "abc" back-to-back → identical second block with `blk_first`=1.
- **Reset mid-message**: 20 bytes accepted, `rst` low 1 cycle → `blk_valid`=0, `in_ready`=1 next cycle. A following "abc" produces exactly the block from the first scenario (word15=0x00000018).

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants and types for the SHA-256 front end
//
// Purpose: block geometry, the padding byte, the length-field width and the
// padder state encoding, shared by the padder, its buffer and its interface.
// Ports: none (package).

package sha256_pkg;

  localparam int         BLK_W       = 512;
  localparam logic [7:0] PAD_BYTE    = 8'h80;
  localparam int         LEN_FIELD_W = 64;

  // Bytes per block and the index of the first length-field byte (56).
  localparam int BLK_BYTES = BLK_W / 8;
  localparam int LEN_POS   = BLK_BYTES - LEN_FIELD_W / 8;

  typedef enum logic [1:0] {
    FILL,
    SEND_MID,
    SEND_X,
    SEND_FINAL
  } pad_state_t;

endpackage

// File: rtl/sha256_padder_if.sv
// rtl/sha256_padder_if.sv - byte-in / block-out handshake bundle for the padder
//
// Purpose: groups the byte input stream and the 512-bit block output stream.
// Signals:
//   in_data/in_valid/in_last/in_empty  byte stream toward the padder
//   in_ready                           padder accepts a byte
//   blk_data/blk_valid/blk_first/blk_last  padded block toward the schedule
//   blk_ready                          downstream consumes the block
// Modports: master = stream source / block sink, slave = padder.

interface sha256_padder_if;
  import sha256_pkg::*;

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_empty;
  logic             in_ready;
  logic [BLK_W-1:0] blk_data;
  logic             blk_valid;
  logic             blk_first;
  logic             blk_last;
  logic             blk_ready;

  modport master (
    output in_data, in_valid, in_last, in_empty, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_first, blk_last
  );

  modport slave (
    input  in_data, in_valid, in_last, in_empty, blk_ready,
    output in_ready, blk_data, blk_valid, blk_first, blk_last
  );

endinterface

// File: rtl/sha256_blk_buf.sv
// rtl/sha256_blk_buf.sv - 64x8 block register file with padding operations
//
// Purpose: holds one 512-bit block under construction. All operations of a
// cycle combine: clear first, then byte write, then 0x80 insert with clear of
// the bytes above it, then the length field over bytes 56..63.
// Ports:
//   clk, rst      clock, synchronous active-low reset (clears the buffer)
//   i_clr         zero the whole buffer
//   i_wr_en/idx/data  write one byte
//   i_pad_en/idx  place 0x80 at idx and zero every byte above idx
//   i_len_en/len  write the 64-bit big-endian length into bytes 56..63
//   o_data        flat block, byte 0 in [511:504]

module sha256_blk_buf
  import sha256_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_wr_en,
  input  logic [5:0]             i_wr_idx,
  input  logic [7:0]             i_wr_data,
  input  logic                   i_pad_en,
  input  logic [5:0]             i_pad_idx,
  input  logic                   i_len_en,
  input  logic [LEN_FIELD_W-1:0] i_len,
  output logic [BLK_W-1:0]       o_data
);

  logic [7:0] r_buf [BLK_BYTES];
  logic [7:0] w_nxt [BLK_BYTES];

  always_comb begin
    for (int i = 0; i < BLK_BYTES; i++) begin
      w_nxt[i] = i_clr ? 8'h00 : r_buf[i];
      if (i_wr_en && (i_wr_idx == 6'(i))) begin
        w_nxt[i] = i_wr_data;
      end
      if (i_pad_en) begin
        if (i_pad_idx == 6'(i)) begin
          w_nxt[i] = PAD_BYTE;
        end else if (6'(i) > i_pad_idx) begin
          w_nxt[i] = 8'h00;
        end
      end
    end
    // Length goes last so it wins over the pad-clear of the top bytes.
    for (int i = LEN_POS; i < BLK_BYTES; i++) begin
      if (i_len_en) begin
        w_nxt[i] = i_len[8*(BLK_BYTES-1-i) +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BLK_BYTES; i++) begin
      if (!rst) begin
        r_buf[i] <= 8'h00;
      end else begin
        r_buf[i] <= w_nxt[i];
      end
    end
  end

  for (genvar g = 0; g < BLK_BYTES; g++) begin : g_flat
    assign o_data[BLK_W-1-8*g -: 8] = r_buf[g];
  end

endmodule

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - FIPS 180-4 message padder producing 512-bit blocks
//
// Purpose: accepts message bytes, appends 0x80, zero fill and the 64-bit
// big-endian bit length, and emits blocks for the message schedule with
// first/last flags for the hash controller.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-low reset
//   bus   sha256_padder_if.slave: byte stream in, block stream out
// Parameter: LEN_W width of the bit-length counter (1..64), zero-extended
//            into the 64-bit length field.

module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic           clk,
  input  logic           rst,
  sha256_padder_if.slave bus
);

  pad_state_t       r_state, w_nxt_state;
  logic [5:0]       r_bcnt, w_nxt_bcnt;
  logic [LEN_W-1:0] r_bitlen, w_nxt_bitlen;
  logic             r_first_pend, w_nxt_first_pend;
  // Whether the 0x80 byte already sits in the block before the tail block.
  logic             r_pad_placed, w_nxt_pad_placed;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_blk_valid;
  logic             w_blk_hs;
  logic             w_has_byte;
  logic [6:0]       w_n;
  logic [LEN_W-1:0] w_bitlen_inc;

  logic                   w_clr;
  logic                   w_wr_en;
  logic [5:0]             w_wr_idx;
  logic [7:0]             w_wr_data;
  logic                   w_pad_en;
  logic [5:0]             w_pad_idx;
  logic                   w_len_en;
  logic [LEN_FIELD_W-1:0] w_len;
  logic [BLK_W-1:0]       w_buf_data;

  assign w_in_ready  = (r_state == FILL) && rst;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_blk_valid = (r_state != FILL);
  assign w_blk_hs    = w_blk_valid && bus.blk_ready;

  // in_empty only matters on the last transfer.
  assign w_has_byte   = !(bus.in_last && bus.in_empty);
  assign w_n          = {1'b0, r_bcnt} + {6'b0, w_has_byte};
  assign w_bitlen_inc = w_has_byte ? (r_bitlen + LEN_W'(8)) : r_bitlen;

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_bcnt       = r_bcnt;
    w_nxt_bitlen     = r_bitlen;
    w_nxt_first_pend = r_first_pend;
    w_nxt_pad_placed = r_pad_placed;
    w_clr            = 1'b0;
    w_wr_en          = 1'b0;
    w_wr_idx         = r_bcnt;
    w_wr_data        = bus.in_data;
    w_pad_en         = 1'b0;
    w_pad_idx        = w_n[5:0];
    w_len_en         = 1'b0;
    w_len            = LEN_FIELD_W'(w_bitlen_inc);

    case (r_state)
      FILL: begin
        if (w_accept) begin
          w_wr_en      = w_has_byte;
          w_nxt_bitlen = w_bitlen_inc;
          if (!bus.in_last) begin
            // bcnt wraps to 0 naturally when the block fills.
            w_nxt_bcnt = r_bcnt + 6'd1;
            if (r_bcnt == 6'd63) begin
              w_nxt_state = SEND_MID;
            end
          end else if (w_n <= 7'(LEN_POS - 1)) begin
            // Pad byte and length both fit in this block.
            w_pad_en    = 1'b1;
            w_len_en    = 1'b1;
            w_nxt_state = SEND_FINAL;
          end else if (w_n < 7'(BLK_BYTES)) begin
            w_pad_en         = 1'b1;
            w_nxt_pad_placed = 1'b1;
            w_nxt_state      = SEND_X;
          end else begin
            // Exactly full: block goes out as is, tail carries the 0x80.
            w_nxt_pad_placed = 1'b0;
            w_nxt_state      = SEND_X;
          end
        end
      end
      SEND_MID: begin
        if (w_blk_hs) begin
          w_nxt_first_pend = 1'b0;
          w_nxt_state      = FILL;
        end
      end
      SEND_X: begin
        if (w_blk_hs) begin
          w_clr            = 1'b1;
          w_pad_en         = !r_pad_placed;
          w_pad_idx        = 6'd0;
          w_len_en         = 1'b1;
          w_len            = LEN_FIELD_W'(r_bitlen);
          w_nxt_first_pend = 1'b0;
          w_nxt_state      = SEND_FINAL;
        end
      end
      SEND_FINAL: begin
        if (w_blk_hs) begin
          w_clr            = 1'b1;
          w_nxt_bitlen     = '0;
          w_nxt_bcnt       = 6'd0;
          w_nxt_first_pend = 1'b1;
          w_nxt_state      = FILL;
        end
      end
      default: begin
        w_nxt_state = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= FILL;
      r_bcnt       <= 6'd0;
      r_bitlen     <= '0;
      r_first_pend <= 1'b1;
      r_pad_placed <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_bcnt       <= w_nxt_bcnt;
      r_bitlen     <= w_nxt_bitlen;
      r_first_pend <= w_nxt_first_pend;
      r_pad_placed <= w_nxt_pad_placed;
    end
  end

  sha256_blk_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (w_wr_data),
    .i_pad_en  (w_pad_en),
    .i_pad_idx (w_pad_idx),
    .i_len_en  (w_len_en),
    .i_len     (w_len),
    .o_data    (w_buf_data)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.blk_valid = w_blk_valid;
  assign bus.blk_first = r_first_pend && w_blk_valid;
  assign bus.blk_last  = (r_state == SEND_FINAL);
  assign bus.blk_data  = w_buf_data;

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - directed self-checking bench for sha256_padder
//
// Purpose: drives directed messages and compares blocks and flags with
// hand-computed padded blocks.
// Ports: none (top-level bench).

module tb_sha256_padder;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha256_padder_if bus ();

  sha256_padder #(.LEN_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]       msg [$];
  logic [BLK_W-1:0] exp_abc;

  task automatic set_bytes(input int n, input logic [7:0] v);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(v);
  endtask

  task automatic set_abc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  function automatic logic [BLK_W-1:0] fill_block(input int n, input logic [7:0] v);
    logic [BLK_W-1:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[BLK_W-1-8*i -: 8] = v;
    return b;
  endfunction

  // Returns right after the edge that accepts the final byte.
  task automatic send_msg(input bit do_last);
    for (int k = 0; k < msg.size(); k++) begin
      int t;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = msg[k];
      bus.in_last  = do_last && (k == msg.size() - 1);
      bus.in_empty = 1'b0;
      t = 0;
      while (bus.in_ready !== 1'b1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        n_total++;
        $display("FAIL send_timeout byte %0d: in_ready never 1 within %0d cycles", k, t);
      end
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_empty();
    int t;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.in_last  = 1'b1;
    bus.in_empty = 1'b1;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_total++;
      $display("FAIL send_empty_timeout: in_ready never 1 within %0d cycles", t);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
  endtask

  task automatic get_block(output logic [BLK_W-1:0] d, output logic f, output logic l,
                           output int waited);
    waited = 0;
    @(negedge clk);
    while (bus.blk_valid !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) begin
      n_total++;
      $display("FAIL blk_timeout: blk_valid never 1 within %0d cycles", waited);
    end
    d = bus.blk_data;
    f = bus.blk_first;
    l = bus.blk_last;
    bus.blk_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready_low got %b want 0", bus.in_ready); else n_pass++;
    n_total++; if (bus.blk_valid !== 1'b0) $display("FAIL rst_blk_valid got %b want 0", bus.blk_valid); else n_pass++;
    n_total++; if (bus.blk_first !== 1'b0) $display("FAIL rst_blk_first got %b want 0", bus.blk_first); else n_pass++;
    n_total++; if (bus.blk_last !== 1'b0) $display("FAIL rst_blk_last got %b want 0", bus.blk_last); else n_pass++;
    n_total++; if (bus.blk_data !== '0) $display("FAIL rst_blk_data got %h want 0", bus.blk_data); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready_after got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_abc();
    logic [BLK_W-1:0] d; logic f, l; int w;
    bus.blk_ready = 1'b1;
    set_abc();
    send_msg(1'b1);
    get_block(d, f, l, w);
    n_total++; if (w !== 0) $display("FAIL abc_latency got %0d want 0 extra cycles", w); else n_pass++;
    n_total++; if (d !== exp_abc) $display("FAIL abc_data got %h want %h", d, exp_abc); else n_pass++;
    n_total++; if (f !== 1'b1) $display("FAIL abc_first got %b want 1", f); else n_pass++;
    n_total++; if (l !== 1'b1) $display("FAIL abc_last got %b want 1", l); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.blk_valid !== 1'b0) $display("FAIL abc_single_block got valid %b want 0", bus.blk_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL abc_in_ready_after got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_empty();
    logic [BLK_W-1:0] d, e; logic f, l; int w;
    e = '0;
    e[511:480] = 32'h80000000;
    send_empty();
    get_block(d, f, l, w);
    n_total++; if (d !== e) $display("FAIL empty_data got %h want %h", d, e); else n_pass++;
    n_total++; if (f !== 1'b1) $display("FAIL empty_first got %b want 1", f); else n_pass++;
    n_total++; if (l !== 1'b1) $display("FAIL empty_last got %b want 1", l); else n_pass++;
  endtask

  task automatic test_pad55();
    logic [BLK_W-1:0] d, e; logic f, l; int w;
    e = fill_block(55, 8'h61);
    e[BLK_W-1-8*55 -: 8] = 8'h80;
    e[31:0] = 32'h000001B8;
    set_bytes(55, 8'h61);
    send_msg(1'b1);
    get_block(d, f, l, w);
    n_total++; if (d !== e) $display("FAIL pad55_data got %h want %h", d, e); else n_pass++;
    n_total++; if (f !== 1'b1) $display("FAIL pad55_first got %b want 1", f); else n_pass++;
    n_total++; if (l !== 1'b1) $display("FAIL pad55_last got %b want 1", l); else n_pass++;
  endtask

  task automatic test_pad56();
    logic [BLK_W-1:0] d, e1, e2; logic f, l; int w;
    e1 = fill_block(56, 8'h61);
    e1[BLK_W-1-8*56 -: 8] = 8'h80;
    e2 = '0;
    e2[31:0] = 32'h000001C0;
    set_bytes(56, 8'h61);
    send_msg(1'b1);
    get_block(d, f, l, w);
    n_total++; if (d !== e1) $display("FAIL pad56_b1_data got %h want %h", d, e1); else n_pass++;
    n_total++; if (f !== 1'b1) $display("FAIL pad56_b1_first got %b want 1", f); else n_pass++;
    n_total++; if (l !== 1'b0) $display("FAIL pad56_b1_last got %b want 0", l); else n_pass++;
    get_block(d, f, l, w);
    n_total++; if (w !== 0) $display("FAIL pad56_tail_latency got %0d want 0", w); else n_pass++;
    n_total++; if (d !== e2) $display("FAIL pad56_b2_data got %h want %h", d, e2); else n_pass++;
    n_total++; if (f !== 1'b0) $display("FAIL pad56_b2_first got %b want 0", f); else n_pass++;
    n_total++; if (l !== 1'b1) $display("FAIL pad56_b2_last got %b want 1", l); else n_pass++;
  endtask

  task automatic test_full64();
    logic [BLK_W-1:0] d, e1, e2; logic f, l; int w;
    e1 = fill_block(64, 8'h61);
    e2 = '0;
    e2[511:480] = 32'h80000000;
    e2[31:0]    = 32'h00000200;
    set_bytes(64, 8'h61);
    send_msg(1'b1);
    get_block(d, f, l, w);
    n_total++; if (d !== e1) $display("FAIL full64_b1_data got %h want %h", d, e1); else n_pass++;
    n_total++; if (f !== 1'b1) $display("FAIL full64_b1_first got %b want 1", f); else n_pass++;
    n_total++; if (l !== 1'b0) $display("FAIL full64_b1_last got %b want 0", l); else n_pass++;
    get_block(d, f, l, w);
    n_total++; if (d !== e2) $display("FAIL full64_b2_data got %h want %h", d, e2); else n_pass++;
    n_total++; if (f !== 1'b0) $display("FAIL full64_b2_first got %b want 0", f); else n_pass++;
    n_total++; if (l !== 1'b1) $display("FAIL full64_b2_last got %b want 1", l); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [BLK_W-1:0] d; logic f, l; int w;
    bus.blk_ready = 1'b0;
    set_abc();
    send_msg(1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_total++; if (bus.blk_valid !== 1'b1) $display("FAIL bp_valid cyc %0d got %b want 1", c, bus.blk_valid); else n_pass++;
      n_total++; if (bus.blk_data !== exp_abc) $display("FAIL bp_data cyc %0d got %h want %h", c, bus.blk_data, exp_abc); else n_pass++;
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %b want 0", c, bus.in_ready); else n_pass++;
      // Offer a stray byte that must not be taken while the block waits.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      bus.in_last  = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    get_block(d, f, l, w);
    n_total++; if (d !== exp_abc) $display("FAIL bp_b1_data got %h want %h", d, exp_abc); else n_pass++;
    n_total++; if (f !== 1'b1) $display("FAIL bp_b1_first got %b want 1", f); else n_pass++;
    set_abc();
    send_msg(1'b1);
    get_block(d, f, l, w);
    n_total++; if (d !== exp_abc) $display("FAIL bp_b2_data got %h want %h", d, exp_abc); else n_pass++;
    n_total++; if (f !== 1'b1) $display("FAIL bp_b2_first got %b want 1", f); else n_pass++;
    n_total++; if (l !== 1'b1) $display("FAIL bp_b2_last got %b want 1", l); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [BLK_W-1:0] d; logic f, l; int w;
    set_bytes(20, 8'h5A);
    send_msg(1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++; if (bus.blk_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", bus.blk_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", bus.in_ready); else n_pass++;
    set_abc();
    send_msg(1'b1);
    get_block(d, f, l, w);
    n_total++; if (d !== exp_abc) $display("FAIL rstmid_data got %h want %h", d, exp_abc); else n_pass++;
    n_total++; if (f !== 1'b1) $display("FAIL rstmid_first got %b want 1", f); else n_pass++;
    n_total++; if (l !== 1'b1) $display("FAIL rstmid_last got %b want 1", l); else n_pass++;
  endtask

  initial begin
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_empty  = 1'b0;
    bus.blk_ready = 1'b0;
    exp_abc = '0;
    exp_abc[511:480] = 32'h61626380;
    exp_abc[31:0]    = 32'h00000018;

    test_reset();
    test_abc();
    test_empty();
    test_pad55();
    test_pad56();
    test_full64();
    test_back_to_back();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
